// File: rtl/vanilla_sb_clear_scheduler_pkg.sv
// Shared types for the scoreboard-clear scheduler: clear request layout and
// the arbitration source encoding used by the per-port round-robin state.
package vanilla_sb_clear_scheduler_pkg;

  typedef struct packed {
    logic       float;
    logic [4:0] id;
  } sb_clear_req_s;

  typedef enum logic {
    e_src_remote = 1'b0,
    e_src_div    = 1'b1
  } sb_src_e;

endpackage

// File: rtl/vanilla_sb_clear_fifo.sv
// In-order 1r1w FIFO for remote responses. No bypass: an entry becomes
// visible at the head the cycle after it is written.
module vanilla_sb_clear_fifo #(
  parameter int width_p = 6,
  parameter int els_p   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enq_v,
  input  logic [width_p-1:0]           enq_data,
  output logic                         ready,
  output logic                         head_v,
  output logic [width_p-1:0]           head_data,
  input  logic                         deq,
  output logic [$clog2(els_p+1)-1:0]   count
);

  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p+1);

  logic [width_p-1:0] mem [els_p];
  logic [ptr_w-1:0]   wptr, rptr;
  logic               enq;

  // Ready looks only at occupancy, so a full FIFO stalls a cycle even
  // while it is draining.
  assign ready     = (count != cnt_w'(els_p));
  assign head_v    = (count != '0);
  assign head_data = mem[rptr];
  assign enq       = enq_v & ready;

  always_ff @(posedge clk) begin
    if (enq) mem[wptr] <= enq_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (enq) wptr <= wptr + 1'b1;
      if (deq) rptr <= rptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vanilla_sb_clear_scheduler.sv
// Arbitrates remote, idiv and fdiv completions onto the int/float scoreboard
// clear ports with independent 2-way round-robin per port; clears are registered.
module vanilla_sb_clear_scheduler
  import vanilla_sb_clear_scheduler_pkg::*;
#(
  parameter int reg_addr_width_p = 5,
  parameter int fifo_els_p       = 4
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              stall_all_i,
  input  logic                              remote_v_i,
  input  logic                              remote_float_i,
  input  logic [reg_addr_width_p-1:0]       remote_id_i,
  output logic                              remote_ready_o,
  input  logic                              idiv_v_i,
  input  logic [reg_addr_width_p-1:0]       idiv_id_i,
  output logic                              idiv_yumi_o,
  input  logic                              fdiv_v_i,
  input  logic [reg_addr_width_p-1:0]       fdiv_id_i,
  output logic                              fdiv_yumi_o,
  output logic                              int_sb_clear_o,
  output logic [reg_addr_width_p-1:0]       int_sb_clear_id_o,
  output logic                              float_sb_clear_o,
  output logic [reg_addr_width_p-1:0]       float_sb_clear_id_o,
  output logic [$clog2(fifo_els_p+1)-1:0]   fifo_count_o
);

  logic                        head_v, head_float, deq;
  logic [reg_addr_width_p-1:0] head_id;

  vanilla_sb_clear_fifo #(
    .width_p (reg_addr_width_p+1),
    .els_p   (fifo_els_p)
  ) fifo (
    .clk       (clk_i),
    .rst_n     (reset_n_i),
    .enq_v     (remote_v_i),
    .enq_data  ({remote_float_i, remote_id_i}),
    .ready     (remote_ready_o),
    .head_v    (head_v),
    .head_data ({head_float, head_id}),
    .deq       (deq),
    .count     (fifo_count_o)
  );

  sb_src_e last_int_r, last_float_r;
  logic    int_rem_req, int_div_req, flt_rem_req, flt_div_req;
  logic    int_rem_gnt, int_div_gnt, flt_rem_gnt, flt_div_gnt;

  // Head competes only on the port named by its float bit.
  assign int_rem_req = head_v & ~head_float & ~stall_all_i;
  assign flt_rem_req = head_v &  head_float & ~stall_all_i;
  assign int_div_req = idiv_v_i & ~stall_all_i;
  assign flt_div_req = fdiv_v_i & ~stall_all_i;

  // On contention the source that lost last time wins.
  assign int_rem_gnt = int_rem_req & (~int_div_req | (last_int_r   == e_src_div));
  assign int_div_gnt = int_div_req & (~int_rem_req | (last_int_r   == e_src_remote));
  assign flt_rem_gnt = flt_rem_req & (~flt_div_req | (last_float_r == e_src_div));
  assign flt_div_gnt = flt_div_req & (~flt_rem_req | (last_float_r == e_src_remote));

  assign deq         = int_rem_gnt | flt_rem_gnt;
  assign idiv_yumi_o = int_div_gnt;
  assign fdiv_yumi_o = flt_div_gnt;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_int_r          <= e_src_div;
      last_float_r        <= e_src_div;
      int_sb_clear_o      <= 1'b0;
      int_sb_clear_id_o   <= '0;
      float_sb_clear_o    <= 1'b0;
      float_sb_clear_id_o <= '0;
    end else begin
      int_sb_clear_o   <= int_rem_gnt | int_div_gnt;
      float_sb_clear_o <= flt_rem_gnt | flt_div_gnt;
      if (int_rem_gnt) begin
        last_int_r        <= e_src_remote;
        int_sb_clear_id_o <= head_id;
      end else if (int_div_gnt) begin
        last_int_r        <= e_src_div;
        int_sb_clear_id_o <= idiv_id_i;
      end
      if (flt_rem_gnt) begin
        last_float_r        <= e_src_remote;
        float_sb_clear_id_o <= head_id;
      end else if (flt_div_gnt) begin
        last_float_r        <= e_src_div;
        float_sb_clear_id_o <= fdiv_id_i;
      end
    end
  end

  a_no_enq_when_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    remote_v_i |-> remote_ready_o);
  a_idiv_held: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (idiv_v_i && !idiv_yumi_o) |=> idiv_v_i);
  a_fdiv_held: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (fdiv_v_i && !fdiv_yumi_o) |=> fdiv_v_i);

endmodule

// File: tb/tb_vanilla_sb_clear_scheduler.sv
// Directed bench for the scoreboard-clear scheduler: divider, remote,
// contention, full FIFO, dual-port clears and mid-run reset.
module tb_vanilla_sb_clear_scheduler;

  logic       clk = 1'b0;
  logic       reset_n, stall_all;
  logic       remote_v, remote_float, remote_ready;
  logic [4:0] remote_id;
  logic       idiv_v, idiv_yumi, fdiv_v, fdiv_yumi;
  logic [4:0] idiv_id, fdiv_id;
  logic       int_clr, flt_clr;
  logic [4:0] int_id, flt_id;
  logic [2:0] count;

  int tests = 0;
  int fails = 0;

  vanilla_sb_clear_scheduler #(.reg_addr_width_p(5), .fifo_els_p(4)) dut (
    .clk_i               (clk),
    .reset_n_i           (reset_n),
    .stall_all_i         (stall_all),
    .remote_v_i          (remote_v),
    .remote_float_i      (remote_float),
    .remote_id_i         (remote_id),
    .remote_ready_o      (remote_ready),
    .idiv_v_i            (idiv_v),
    .idiv_id_i           (idiv_id),
    .idiv_yumi_o         (idiv_yumi),
    .fdiv_v_i            (fdiv_v),
    .fdiv_id_i           (fdiv_id),
    .fdiv_yumi_o         (fdiv_yumi),
    .int_sb_clear_o      (int_clr),
    .int_sb_clear_id_o   (int_id),
    .float_sb_clear_o    (flt_clr),
    .float_sb_clear_id_o (flt_id),
    .fifo_count_o        (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; stall_all = 1'b0;
    remote_v = 1'b0; remote_float = 1'b0; remote_id = '0;
    idiv_v = 1'b0; idiv_id = '0; fdiv_v = 1'b0; fdiv_id = '0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic enq(input logic f, input logic [4:0] id);
    remote_v = 1'b1; remote_float = f; remote_id = id;
    tick();
    remote_v = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; stall_all = 1'b0;
    remote_v = 1'b0; remote_float = 1'b0; remote_id = '0;
    idiv_v = 1'b0; idiv_id = '0; fdiv_v = 1'b0; fdiv_id = '0;
    #3;
    tests++; if ({int_clr, flt_clr, int_id, flt_id} !== 12'h0) begin
      fails++; $display("FAIL reset_clears got %b %b %0d %0d want 0 0 0 0", int_clr, flt_clr, int_id, flt_id); end
    tests++; if (remote_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready got %b want 1", remote_ready); end
    tests++; if (count !== 3'd0) begin
      fails++; $display("FAIL reset_count got %0d want 0", count); end
    tests++; if ({idiv_yumi, fdiv_yumi} !== 2'b00) begin
      fails++; $display("FAIL reset_yumi got %b want 00", {idiv_yumi, fdiv_yumi}); end
    tick(); reset_n = 1'b1;
  endtask

  task automatic test_divider();
    do_reset();
    stall_all = 1'b1; idiv_v = 1'b1; idiv_id = 5'd7;
    #1;
    tests++; if (idiv_yumi !== 1'b0) begin
      fails++; $display("FAIL div_stall_yumi got %b want 0", idiv_yumi); end
    tick();
    tests++; if (int_clr !== 1'b0) begin
      fails++; $display("FAIL div_stall_clear got %b want 0", int_clr); end
    stall_all = 1'b0;
    #1;
    tests++; if (idiv_yumi !== 1'b1) begin
      fails++; $display("FAIL div_yumi got %b want 1", idiv_yumi); end
    tick(); idiv_v = 1'b0;
    tests++; if ({int_clr, int_id, flt_clr} !== {1'b1, 5'd7, 1'b0}) begin
      fails++; $display("FAIL div_clear got %b id %0d flt %b want 1 id 7 flt 0", int_clr, int_id, flt_clr); end
    tick();
    tests++; if ({int_clr, int_id} !== {1'b0, 5'd7}) begin
      fails++; $display("FAIL div_one_shot got %b id %0d want 0 id 7", int_clr, int_id); end
  endtask

  task automatic test_remote_latency();
    do_reset();
    remote_v = 1'b1; remote_float = 1'b0; remote_id = 5'd3;
    #1;
    tests++; if ({count, int_clr} !== {3'd0, 1'b0}) begin
      fails++; $display("FAIL rem_c0 got count %0d clr %b want 0 0", count, int_clr); end
    tick(); remote_v = 1'b0;
    tests++; if ({count, int_clr} !== {3'd1, 1'b0}) begin
      fails++; $display("FAIL rem_c1 got count %0d clr %b want 1 0", count, int_clr); end
    tick();
    tests++; if ({int_clr, int_id, count} !== {1'b1, 5'd3, 3'd0}) begin
      fails++; $display("FAIL rem_c2 got clr %b id %0d count %0d want 1 3 0", int_clr, int_id, count); end
  endtask

  task automatic test_contention();
    do_reset();
    stall_all = 1'b1;
    enq(1'b0, 5'd5); enq(1'b0, 5'd6);
    stall_all = 1'b0; idiv_v = 1'b1; idiv_id = 5'd9;
    #1;
    tests++; if (idiv_yumi !== 1'b0) begin
      fails++; $display("FAIL cont_a_yumi got %b want 0", idiv_yumi); end
    tick();
    tests++; if ({int_clr, int_id, idiv_yumi} !== {1'b1, 5'd5, 1'b1}) begin
      fails++; $display("FAIL cont_b got clr %b id %0d yumi %b want 1 5 1", int_clr, int_id, idiv_yumi); end
    tick(); idiv_id = 5'd10;
    #1;
    tests++; if ({int_clr, int_id, idiv_yumi} !== {1'b1, 5'd9, 1'b0}) begin
      fails++; $display("FAIL cont_c got clr %b id %0d yumi %b want 1 9 0", int_clr, int_id, idiv_yumi); end
    tick();
    tests++; if ({int_clr, int_id, idiv_yumi} !== {1'b1, 5'd6, 1'b1}) begin
      fails++; $display("FAIL cont_d got clr %b id %0d yumi %b want 1 6 1", int_clr, int_id, idiv_yumi); end
    tick(); idiv_v = 1'b0;
    tests++; if ({int_clr, int_id, count} !== {1'b1, 5'd10, 3'd0}) begin
      fails++; $display("FAIL cont_e got clr %b id %0d count %0d want 1 10 0", int_clr, int_id, count); end
  endtask

  task automatic test_full_fifo();
    do_reset();
    stall_all = 1'b1;
    for (int i = 1; i <= 4; i++) enq(1'b0, 5'(i));
    tests++; if ({count, remote_ready} !== {3'd4, 1'b0}) begin
      fails++; $display("FAIL full_state got count %0d ready %b want 4 0", count, remote_ready); end
    stall_all = 1'b0;
    #1;
    tests++; if ({int_clr, remote_ready} !== 2'b00) begin
      fails++; $display("FAIL full_release got clr %b ready %b want 0 0", int_clr, remote_ready); end
    tick();
    tests++; if ({int_clr, int_id, remote_ready, count} !== {1'b1, 5'd1, 1'b1, 3'd3}) begin
      fails++; $display("FAIL full_first got clr %b id %0d ready %b count %0d want 1 1 1 3", int_clr, int_id, remote_ready, count); end
    for (int i = 2; i <= 4; i++) begin
      tick();
      tests++; if ({int_clr, int_id} !== {1'b1, 5'(i)}) begin
        fails++; $display("FAIL full_drain got clr %b id %0d want 1 %0d", int_clr, int_id, i); end
    end
    tick();
    tests++; if ({int_clr, count} !== {1'b0, 3'd0}) begin
      fails++; $display("FAIL full_empty got clr %b count %0d want 0 0", int_clr, count); end
  endtask

  task automatic test_dual_port();
    do_reset();
    stall_all = 1'b1; enq(1'b1, 5'd2);
    stall_all = 1'b0; idiv_v = 1'b1; idiv_id = 5'd4;
    #1;
    tests++; if (idiv_yumi !== 1'b1) begin
      fails++; $display("FAIL dual_yumi got %b want 1", idiv_yumi); end
    tick(); idiv_v = 1'b0;
    tests++; if ({int_clr, int_id, flt_clr, flt_id} !== {1'b1, 5'd4, 1'b1, 5'd2}) begin
      fails++; $display("FAIL dual_clear got %b %0d %b %0d want 1 4 1 2", int_clr, int_id, flt_clr, flt_id); end
    tick();
    tests++; if ({int_clr, int_id, flt_clr, flt_id} !== {1'b0, 5'd4, 1'b0, 5'd2}) begin
      fails++; $display("FAIL dual_hold got %b %0d %b %0d want 0 4 0 2", int_clr, int_id, flt_clr, flt_id); end
    stall_all = 1'b1; enq(1'b0, 5'd6);
    stall_all = 1'b0; fdiv_v = 1'b1; fdiv_id = 5'd11;
    #1;
    tests++; if ({fdiv_yumi, idiv_yumi} !== 2'b10) begin
      fails++; $display("FAIL dual_fdiv_yumi got %b want 10", {fdiv_yumi, idiv_yumi}); end
    tick(); fdiv_v = 1'b0;
    tests++; if ({int_clr, int_id, flt_clr, flt_id} !== {1'b1, 5'd6, 1'b1, 5'd11}) begin
      fails++; $display("FAIL dual_fdiv got %b %0d %b %0d want 1 6 1 11", int_clr, int_id, flt_clr, flt_id); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    stall_all = 1'b1;
    for (int i = 1; i <= 4; i++) enq(1'b1, 5'(i));
    stall_all = 1'b0;
    tick(); stall_all = 1'b1;
    tests++; if ({flt_clr, flt_id, count} !== {1'b1, 5'd1, 3'd3}) begin
      fails++; $display("FAIL mid_pre got clr %b id %0d count %0d want 1 1 3", flt_clr, flt_id, count); end
    #2 reset_n = 1'b0;
    #1;
    tests++; if ({flt_clr, count, remote_ready, flt_id} !== {1'b0, 3'd0, 1'b1, 5'd0}) begin
      fails++; $display("FAIL mid_reset got clr %b count %0d ready %b id %0d want 0 0 1 0", flt_clr, count, remote_ready, flt_id); end
    tick(); reset_n = 1'b1; stall_all = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if ({int_clr, flt_clr, count} !== 5'd0) begin
        fails++; $display("FAIL mid_stale got int %b flt %b count %0d want 0 0 0", int_clr, flt_clr, count); end
    end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_remote_latency();
    test_contention();
    test_full_fifo();
    test_dual_port();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
